screen_fetch: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/screen_fetch_if.sv | 12 +
 rtl/pixel_shifter.sv | 37 +++
 rtl/screen_fetch.sv | 114 +++++++++++
 tb/tb_screen_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing, Hack screen geometry and 3/3/2 colour definitions.
// Used by the screen fetch path and its memory interface.
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int HACK_WIDTH         = 512;
  localparam int HACK_HEIGHT        = 256;
  localparam int HACK_WORDS_PER_ROW = 32;
  localparam int HACK_ADDR_W        = 13;
  localparam int HACK_WORD_W        = 16;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } colour_t;

  localparam colour_t COLOUR_WHITE  = '{red: 3'd7, green: 3'd7, blue: 2'd3};
  localparam colour_t COLOUR_BLACK  = '{red: 3'd0, green: 3'd0, blue: 2'd0};
  localparam colour_t COLOUR_BG     = '{red: 3'd0, green: 3'd0, blue: 2'd1};
  localparam colour_t COLOUR_BORDER = '{red: 3'd7, green: 3'd0, blue: 2'd0};

  // Screen RAM word address: row in the upper bits, word within the row below.
  function automatic logic [HACK_ADDR_W-1:0] hack_addr(input logic [7:0] row,
                                                       input logic [4:0] word);
    return {row, word};
  endfunction

endpackage

// File: rtl/screen_fetch_if.sv
// Screen RAM read port: the fetcher drives address/strobe, the RAM returns
// data one cycle after sampling them.
interface screen_fetch_if;
  import vga_pkg::*;

  logic [HACK_ADDR_W-1:0] mem_addr;
  logic                   mem_rd;
  logic [HACK_WORD_W-1:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/pixel_shifter.sv
// 16-bit load/shift register; bit 0 is the current pixel, shifting right
// walks the Hack word left-to-right across the screen.
module pixel_shifter
  import vga_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [HACK_WORD_W-1:0] data,
  output logic                   pixel
);

  logic [HACK_WORD_W-1:0] shreg_reg;
  logic [HACK_WORD_W-1:0] shreg_next;

  genvar gi;
  generate
    for (gi = 0; gi < HACK_WORD_W; gi++) begin : g_bit
      if (gi == HACK_WORD_W - 1) begin : g_top
        assign shreg_next[gi] = load ? data[gi] : 1'b0;
      end else begin : g_mid
        assign shreg_next[gi] = load ? data[gi] : shreg_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= shreg_next;
    end
  end

  assign pixel = shreg_reg[0];

endmodule

// File: rtl/screen_fetch.sv
// Fetches Hack screen words from the VGA counters and paints the centred window.
// Define SCREEN_FETCH_BORDER_EN to draw a red 1-pixel ring around the window.
module screen_fetch
  import vga_pkg::*;
#(
  parameter int X_OFFSET  = 64,
  parameter int Y_OFFSET  = 112,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [9:0]     hcount,
  input  logic [9:0]     vcount,
  screen_fetch_if.master mem,
  output logic [2:0]     Red,
  output logic [2:0]     Green,
  output logic [1:0]     Blue
);

  // Decision two cycles ahead of the registered strobe reaching the RAM.
  localparam int FETCH_FIRST = X_OFFSET - 3;
  localparam int CAP_FIRST   = X_OFFSET - 1;

  logic       win_row;
  logic       win_col;
  logic       blank;
  logic       fetch_hit;
  logic       capture;
  logic [8:0] fetch_rel;
  logic [3:0] cap_rel;
  logic [7:0] row;
  logic       pixel;

  logic                   mem_rd_reg;
  logic [HACK_ADDR_W-1:0] mem_addr_reg;
  colour_t                colour_reg;
  colour_t                colour_next;

  assign win_row = (vcount >= 10'(Y_OFFSET)) && (vcount < 10'(Y_OFFSET + HACK_HEIGHT));
  assign win_col = (hcount >= 10'(X_OFFSET)) && (hcount < 10'(X_OFFSET + HACK_WIDTH));
  assign blank   = (hcount >= 10'(H_DISPLAY)) || (vcount >= 10'(V_DISPLAY));
  assign row     = 8'(vcount - 10'(Y_OFFSET));

  assign fetch_rel = 9'(hcount - 10'(FETCH_FIRST));
  assign fetch_hit = win_row && (hcount >= 10'(FETCH_FIRST))
                   && (hcount < 10'(FETCH_FIRST + HACK_WIDTH)) && (fetch_rel[3:0] == 4'd0);

  assign cap_rel = 4'(hcount - 10'(CAP_FIRST));
  assign capture = win_row && (hcount >= 10'(CAP_FIRST))
                 && (hcount < 10'(CAP_FIRST + HACK_WIDTH)) && (cap_rel == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      mem_rd_reg <= fetch_hit;
      if (fetch_hit) begin
        mem_addr_reg <= hack_addr(row, fetch_rel[8:4]);
      end
    end
  end

  assign mem.mem_rd   = mem_rd_reg;
  assign mem.mem_addr = mem_addr_reg;

  pixel_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (capture),
    .data  (mem.mem_data),
    .pixel (pixel)
  );

`ifdef SCREEN_FETCH_BORDER_EN
  logic ring_col;
  logic ring_row;
  logic ring;

  // Ring spans one pixel beyond the window on every side, corners included.
  assign ring_col = ((hcount == 10'(X_OFFSET - 1)) || (hcount == 10'(X_OFFSET + HACK_WIDTH)))
                  && (vcount >= 10'(Y_OFFSET - 1)) && (vcount <= 10'(Y_OFFSET + HACK_HEIGHT));
  assign ring_row = ((vcount == 10'(Y_OFFSET - 1)) || (vcount == 10'(Y_OFFSET + HACK_HEIGHT)))
                  && (hcount >= 10'(X_OFFSET - 1)) && (hcount <= 10'(X_OFFSET + HACK_WIDTH));
  assign ring     = ring_col || ring_row;
`endif

  always_comb begin
    colour_next = COLOUR_BG;
    if (blank) begin
      colour_next = COLOUR_BLACK;
    end else if (win_row && win_col) begin
      colour_next = pixel ? COLOUR_BLACK : COLOUR_WHITE;
`ifdef SCREEN_FETCH_BORDER_EN
    end else if (ring) begin
      colour_next = COLOUR_BORDER;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour_reg <= COLOUR_BLACK;
    end else begin
      colour_reg <= colour_next;
    end
  end

  assign Red   = colour_reg.red;
  assign Green = colour_reg.green;
  assign Blue  = colour_reg.blue;

endmodule

// File: tb/tb_screen_fetch.sv
// Self-checking bench for screen_fetch: per-cycle model of the expected
// colour/fetch stream plus literal checks on selected pixels and strobes.
module tb_screen_fetch;

  localparam int X = 64;
  localparam int Y = 112;
`ifdef SCREEN_FETCH_BORDER_EN
  localparam logic [7:0] RING_COL = 8'hE0;
`else
  localparam logic [7:0] RING_COL = 8'h01;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [2:0] red_o;
  logic [2:0] green_o;
  logic [1:0] blue_o;

  screen_fetch_if mem_bus ();

  screen_fetch dut (
    .clk    (clk),
    .reset  (rst_n),
    .hcount (hcount),
    .vcount (vcount),
    .mem    (mem_bus),
    .Red    (red_o),
    .Green  (green_o),
    .Blue   (blue_o)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:8191];

  // Synchronous-read screen RAM.
  always @(posedge clk) begin
    if (mem_bus.mem_rd) mem_bus.mem_data <= ram[mem_bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          prev_h = 0;
  int          prev_v = 0;
  bit          prev_rst = 1'b0;
  bit          have_prev = 1'b0;
  bit          run_ok = 1'b0;
  int          run_start = 0;
  bit          known_zero = 1'b0;
  logic [12:0] m_addr = '0;
  int          line_pulses = 0;

  logic [7:0]  obs_col  [0:799];
  logic        obs_rd   [0:799];
  logic [12:0] obs_addr [0:799];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (prev h=%0d v=%0d)", name, got, exp, prev_h, prev_v);
    end
  endtask

  // Expected outputs in a cycle are derived from the counters of the previous cycle.
  always @(negedge clk) begin : cmp
    logic [7:0]  got_col;
    logic [7:0]  exp_col;
    logic        exp_rd;
    bit          chk_col;
    bit          in_row;
    int          h, v, k, fh;
    logic [15:0] w;
    got_col = {red_o, green_o, blue_o};
    chk_col = 1'b1;
    exp_col = 8'h00;
    exp_rd  = 1'b0;
    if (!rst_n) begin
      m_addr = '0;
    end else if (have_prev && prev_rst) begin
      h = prev_h;
      v = prev_v;
      in_row = (v >= Y) && (v < Y + 256);
      fh = h - (X - 3);
      if (in_row && fh >= 0 && fh <= 496 && (fh % 16) == 0) begin
        exp_rd = 1'b1;
        m_addr = 13'((v - Y) * 32 + fh / 16);
      end
      if (h >= 640 || v >= 480) begin
        exp_col = 8'h00;
      end else if (in_row && h >= X && h < X + 512) begin
        k = (h - X) / 16;
        w = ram[(v - Y) * 32 + k];
        if (run_start <= X - 3 + 16 * k) exp_col = w[(h - X) % 16] ? 8'h00 : 8'hFF;
        else if (known_zero) exp_col = 8'hFF;
        else chk_col = 1'b0;
      end else if ((((h == X - 1) || (h == X + 512)) && v >= Y - 1 && v <= Y + 256) ||
                   (((v == Y - 1) || (v == Y + 256)) && h >= X - 1 && h <= X + 512)) begin
        exp_col = RING_COL;
      end else begin
        exp_col = 8'h01;
      end
    end
    if (have_prev) begin
      if (chk_col) check("colour", 32'(got_col), 32'(exp_col));
      check("mem_rd", 32'(mem_bus.mem_rd), 32'(exp_rd));
      check("mem_addr", 32'(mem_bus.mem_addr), 32'(m_addr));
      if (prev_h < 800) obs_col[prev_h] = got_col;
    end
    obs_rd[hcount]   = mem_bus.mem_rd;
    obs_addr[hcount] = mem_bus.mem_addr;
    if (mem_bus.mem_rd) line_pulses++;
    if (!rst_n) begin
      run_ok = 1'b0;
    end else if (!run_ok || !prev_rst || int'(hcount) != prev_h + 1 || int'(vcount) != prev_v) begin
      run_start  = int'(hcount);
      known_zero = !prev_rst;
      run_ok     = 1'b1;
    end
    prev_h    = int'(hcount);
    prev_v    = int'(vcount);
    prev_rst  = rst_n;
    have_prev = 1'b1;
  end

  task automatic drive(input int h, input int v, input bit r);
    @(posedge clk);
    #1;
    hcount = 10'(h);
    vcount = 10'(v);
    rst_n  = r;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 800; i++) begin
      obs_col[i]  = 8'h5A;
      obs_rd[i]   = 1'b0;
      obs_addr[i] = '0;
    end
    line_pulses = 0;
  endtask

  task automatic run_line(input int v, input int h0, input int h1);
    clear_obs();
    for (int h = h0; h <= h1; h++) drive(h, v, 1'b1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
    ram[0] = 16'h0001;
    ram[3] = 16'h8000;
    ram[5] = 16'hA5C3;
    for (int k = 0; k < 32; k++) ram[255 * 32 + k] = 16'(k * 16'h0841) ^ 16'h3C3C;
    for (int k = 0; k < 32; k++) ram[38 * 32 + k] = 16'hFFFF;
    rst_n  = 1'b0;
    hcount = '0;
    vcount = '0;
    repeat (4) drive(0, 0, 1'b0);
    check("reset_rgb", 32'({red_o, green_o, blue_o}), 32'h0);
    check("reset_rd", 32'(mem_bus.mem_rd), 32'h0);
    check("reset_addr", 32'(mem_bus.mem_addr), 32'h0);

    // Row 0: word 0 = 0001, word 3 = 8000
    run_line(112, 60, 799);
    $display("line v=112: pulses=%0d", line_pulses);
    check("r0_rd62", 32'(obs_rd[62]), 32'h1);
    check("r0_rd61", 32'(obs_rd[61]), 32'h0);
    check("r0_addr62", 32'(obs_addr[62]), 32'h0);
    check("r0_col64", 32'(obs_col[64]), 32'h00);
    check("r0_col65", 32'(obs_col[65]), 32'hFF);
    check("r0_col79", 32'(obs_col[79]), 32'hFF);
    check("r0_col126", 32'(obs_col[126]), 32'hFF);
    check("r0_col127", 32'(obs_col[127]), 32'h00);
    check("r0_pulses", 32'(line_pulses), 32'd32);

    // Row 255: address mapping
    run_line(367, 0, 799);
    $display("line v=367: pulses=%0d", line_pulses);
    check("r255_rd558", 32'(obs_rd[558]), 32'h1);
    check("r255_addr558", 32'(obs_addr[558]), 32'h1FFF);
    check("r255_addr62", 32'(obs_addr[62]), 32'h1FE0);
    check("r255_pulses", 32'(line_pulses), 32'd32);

    // Outside the window
    run_line(50, 0, 799);
    $display("line v=50: pulses=%0d", line_pulses);
    check("out_pulses", 32'(line_pulses), 32'd0);
    check("out_col0", 32'(obs_col[0]), 32'h01);
    check("out_col639", 32'(obs_col[639]), 32'h01);
    check("out_col640", 32'(obs_col[640]), 32'h00);
    check("out_col799", 32'(obs_col[799]), 32'h00);

    // Reset mid-line on an all-black row
    clear_obs();
    for (int h = 0; h < 800; h++) drive(h, 150, !(h >= 200 && h < 210));
    @(negedge clk);
    #1;
    $display("line v=150 with reset: pulses=%0d", line_pulses);
    check("rst_col190", 32'(obs_col[190]), 32'h00);
    check("rst_rd205", 32'(obs_rd[205]), 32'h0);
    check("rst_col215", 32'(obs_col[215]), 32'hFF);
    check("rst_col223", 32'(obs_col[223]), 32'hFF);
    check("rst_col224", 32'(obs_col[224]), 32'h00);

    // Ring column at hcount 63
    run_line(200, 0, 799);
    $display("line v=200: pulses=%0d", line_pulses);
    check("ring_col63", 32'(obs_col[63]), 32'(RING_COL));
    check("ring_col62", 32'(obs_col[62]), 32'h01);
    check("ring_col64", 32'(obs_col[64]), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
